// File: rtl/fp_div_mant_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_mant_seq
//  Description : Iterative radix-2 restoring mantissa divider for the
//                single-precision FP divide path. Produces
//                Q = floor(dividend * 2^MANT_WIDTH / divisor) and remainder R
//                after MANT_WIDTH+1 iterations, with a ready/start/done
//                handshake and a synchronous abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_div_mant_seq #(
    parameter int MANT_WIDTH = 23,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic                  in_abort,
    input  logic [MANT_WIDTH+1:0] in_dividend,
    input  logic [MANT_WIDTH:0]   in_divisor,
    output logic                  out_ready,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [MANT_WIDTH:0]   out_quotient,
    output logic [MANT_WIDTH:0]   out_remainder,
    output logic                  out_div_by_zero
);

    localparam int c_QW = MANT_WIDTH + 1;   // quotient / divisor width
    localparam int c_PW = MANT_WIDTH + 2;   // partial remainder width
    localparam logic [CNT_WIDTH-1:0] c_LAST_ITER = CNT_WIDTH'(MANT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [c_PW-1:0]        r_p;       // partial remainder
    logic [c_QW-1:0]        r_d;       // latched divisor
    logic [c_QW-1:0]        r_q;       // quotient shift register
    logic                   r_dbz;     // divisor-was-zero, latched at start
    logic [c_QW-1:0]        r_quot_out;
    logic [c_QW-1:0]        r_rem_out;
    logic                   r_dbz_out;

    logic                   w_ge;
    logic [c_PW-1:0]        w_p_sub;
    logic [c_PW-1:0]        w_p_shl;
    logic [c_QW-1:0]        w_q_next;
    logic                   w_last;

    // One restoring step: trial subtract, quotient bit, and pre-shifted remainder
    always_comb begin
        w_ge     = (r_p >= {1'b0, r_d});
        w_p_sub  = w_ge ? (r_p - {1'b0, r_d}) : r_p;
        // After a subtract P < D, so the shift cannot lose a significant bit
        w_p_shl  = w_p_sub << 1;
        w_q_next = {r_q[c_QW-2:0], w_ge};
        w_last   = (r_cnt == c_LAST_ITER);
    end

    // Control FSM, iteration datapath and held result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_p        <= '0;
            r_d        <= '0;
            r_q        <= '0;
            r_dbz      <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_dbz_out  <= 1'b0;
        end else if (in_abort) begin
            // Abort wins over start and over DONE entry; results are untouched
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_d     <= in_divisor;
                        r_p     <= in_dividend;
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_dbz   <= (in_divisor == '0);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Final iteration keeps the remainder unshifted
                        r_p     <= w_p_sub;
                        r_state <= S_DONE;
                        if (r_dbz) begin
                            r_quot_out <= '1;
                            r_rem_out  <= '0;
                            r_dbz_out  <= 1'b1;
                        end else begin
                            r_quot_out <= w_q_next;
                            r_rem_out  <= w_p_sub[c_QW-1:0];
                            r_dbz_out  <= 1'b0;
                        end
                    end else begin
                        r_p <= w_p_shl;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_ready       = (r_state == S_IDLE);
    assign out_busy        = (r_state == S_CALC);
    assign out_done        = (r_state == S_DONE);
    assign out_quotient    = r_quot_out;
    assign out_remainder   = r_rem_out;
    assign out_div_by_zero = r_dbz_out;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_mant_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_div_mant_seq
//  Description : Self-checking bench for fp_div_mant_seq with a result
//                scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_mant_seq;

    typedef struct packed {
        logic [23:0] q;
        logic [23:0] r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic        in_abort;
    logic [24:0] in_dividend;
    logic [23:0] in_divisor;
    logic        out_ready;
    logic        out_busy;
    logic        out_done;
    logic [23:0] out_quotient;
    logic [23:0] out_remainder;
    logic        out_div_by_zero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t last;

    logic [24:0] tv_a [5] = '{25'h0800000, 25'h0800000, 25'h0C00000, 25'h0FFFFFF, 25'h0800000};
    logic [23:0] tv_b [5] = '{24'h800000,  24'hC00000,  24'h800000,  24'h800000,  24'hFFFFFF};
    exp_t        tv_e [5] = '{'{24'h800000, 24'h000000, 1'b0},
                              '{24'h555555, 24'h400000, 1'b0},
                              '{24'hC00000, 24'h000000, 1'b0},
                              '{24'hFFFFFF, 24'h000000, 1'b0},
                              '{24'h400000, 24'h400000, 1'b0}};

    fp_div_mant_seq #(.MANT_WIDTH(23), .CNT_WIDTH(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_start        (in_start),
        .in_abort        (in_abort),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .out_ready       (out_ready),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_quotient    (out_quotient),
        .out_remainder   (out_remainder),
        .out_div_by_zero (out_div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [24:0] a, input logic [23:0] b);
        exp_t        e;
        logic [63:0] num;
        logic [63:0] qq;
        num = {39'd0, a} << 23;
        if (b == 24'd0) begin
            e.q = 24'hFFFFFF; e.r = 24'd0; e.dz = 1'b1;
        end else begin
            qq   = num / {40'd0, b};
            e.q  = qq[23:0];
            e.r  = 24'(num - qq * {40'd0, b});
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Present operands with a one-cycle start; returns #1 after the accepting edge
    task automatic issue(input logic [24:0] a, input logic [23:0] b);
        in_dividend = a;
        in_divisor  = b;
        in_start    = 1'b1;
        @(posedge clk); #1;
        in_start    = 1'b0;
        in_dividend = 25'($urandom);
        in_divisor  = 24'($urandom);
    endtask

    // Edges from now until out_done is seen (0 if it never comes)
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic watch(input int n, output int dones, output int busys);
        dones = 0;
        busys = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_done) dones++;
            if (out_busy) busys++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_start = 1'b0; in_abort = 1'b0;
        in_dividend = '0; in_divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_ready, out_busy, out_done, out_div_by_zero} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got rdy/busy/done/dz=%b expected 1000",
                     {out_ready, out_busy, out_done, out_div_by_zero});
        end
        checks++;
        if (out_quotient !== 24'd0 || out_remainder !== 24'd0) begin
            errors++;
            $display("FAIL reset_data: got Q=%h R=%h expected 0/0", out_quotient, out_remainder);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Plan vectors plus random normalised operands, issued back to back
    task automatic test_back_to_back();
        logic [24:0] a;
        logic [23:0] b;
        exp_t        e;
        exp_t        got;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                a = tv_a[i]; b = tv_b[i]; e = tv_e[i];
            end else begin
                a = {2'b01, 23'($urandom)};
                b = {1'b1, 23'($urandom)};
                e = model(a, b);
            end
            checks++;
            if (out_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, out_ready);
            end
            issue(a, b);
            sb.push_back(e);
            wait_done(lat);
            checks++;
            if (lat !== 24) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got %0d edges expected 24", i, lat);
            end
            if (sb.size() > 0) begin
                got = sb.pop_front();
                checks++;
                if (out_quotient !== got.q || out_remainder !== got.r || out_div_by_zero !== got.dz) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got Q=%h R=%h dz=%b expected Q=%h R=%h dz=%b",
                             i, out_quotient, out_remainder, out_div_by_zero, got.q, got.r, got.dz);
                end
                last = got;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        exp_t got;
        int   lat;
        issue(25'h0800000, 24'h000000);
        sb.push_back('{24'hFFFFFF, 24'h000000, 1'b1});
        wait_done(lat);
        got = sb.pop_front();
        checks++;
        if (lat !== 24 || out_quotient !== got.q || out_remainder !== got.r || out_div_by_zero !== got.dz) begin
            errors++;
            $display("FAIL div_zero: got lat=%0d Q=%h R=%h dz=%b expected lat=24 Q=%h R=%h dz=%b",
                     lat, out_quotient, out_remainder, out_div_by_zero, got.q, got.r, got.dz);
        end
        @(posedge clk); #1;
        issue(25'h0C00000, 24'h800000);
        sb.push_back(model(25'h0C00000, 24'h800000));
        wait_done(lat);
        got = sb.pop_front();
        checks++;
        if (out_quotient !== got.q || out_remainder !== got.r || out_div_by_zero !== got.dz) begin
            errors++;
            $display("FAIL div_zero_clear: got Q=%h R=%h dz=%b expected Q=%h R=%h dz=%b",
                     out_quotient, out_remainder, out_div_by_zero, got.q, got.r, got.dz);
        end
        last = got;
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        exp_t got;
        int   lat;
        int   dones;
        int   busys;
        issue(25'h0800000, 24'hC00000);
        sb.push_back(tv_e[1]);
        repeat (5) @(posedge clk);
        #1;
        in_dividend = 25'h0FFFFFF; in_divisor = 24'h800000; in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        wait_done(lat);
        got = sb.pop_front();
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL ignore_mid_latency: got %0d edges after pulse expected 18", lat);
        end
        checks++;
        if (out_quotient !== got.q || out_remainder !== got.r || out_div_by_zero !== got.dz) begin
            errors++;
            $display("FAIL ignore_mid_result: got Q=%h R=%h dz=%b expected Q=%h R=%h dz=%b",
                     out_quotient, out_remainder, out_div_by_zero, got.q, got.r, got.dz);
        end
        last = got;
        // Start during the DONE cycle must be dropped
        in_dividend = 25'h0C00000; in_divisor = 24'h800000; in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        checks++;
        if ({out_ready, out_busy, out_done} !== 3'b100) begin
            errors++;
            $display("FAIL ignore_done_state: got rdy/busy/done=%b expected 100",
                     {out_ready, out_busy, out_done});
        end
        watch(30, dones, busys);
        checks++;
        if (dones !== 0 || busys !== 0 || out_quotient !== last.q || out_remainder !== last.r) begin
            errors++;
            $display("FAIL ignore_done_quiet: got dones=%0d busy=%0d Q=%h R=%h expected 0 0 Q=%h R=%h",
                     dones, busys, out_quotient, out_remainder, last.q, last.r);
        end
    endtask

    task automatic test_abort();
        int dones;
        int busys;
        // Abort at iteration 10
        issue(25'h0FFFFFF, 24'hFFFFFF);
        repeat (9) @(posedge clk);
        #1;
        in_abort = 1'b1;
        @(posedge clk); #1;
        in_abort = 1'b0;
        checks++;
        if (out_ready !== 1'b1 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got rdy=%b busy=%b expected 1 0", out_ready, out_busy);
        end
        watch(30, dones, busys);
        checks++;
        if (dones !== 0 || out_quotient !== last.q || out_remainder !== last.r || out_div_by_zero !== last.dz) begin
            errors++;
            $display("FAIL abort_hold: got dones=%0d Q=%h R=%h dz=%b expected 0 Q=%h R=%h dz=%b",
                     dones, out_quotient, out_remainder, out_div_by_zero, last.q, last.r, last.dz);
        end
        // Abort coinciding with the final iteration beats DONE entry
        issue(25'h0800000, 24'h000000);
        repeat (23) @(posedge clk);
        #1;
        in_abort = 1'b1;
        @(posedge clk); #1;
        in_abort = 1'b0;
        watch(30, dones, busys);
        checks++;
        if (dones !== 0 || out_quotient !== last.q || out_div_by_zero !== last.dz) begin
            errors++;
            $display("FAIL abort_last_iter: got dones=%0d Q=%h dz=%b expected 0 Q=%h dz=%b",
                     dones, out_quotient, out_div_by_zero, last.q, last.dz);
        end
        // Abort with start in IDLE drops the start
        in_abort = 1'b1; in_start = 1'b1;
        @(posedge clk); #1;
        in_abort = 1'b0; in_start = 1'b0;
        watch(30, dones, busys);
        checks++;
        if (dones !== 0 || busys !== 0 || out_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_with_start: got dones=%0d busy=%0d rdy=%b expected 0 0 1",
                     dones, busys, out_ready);
        end
    endtask

    task automatic test_rst_mid();
        exp_t got;
        int   lat;
        int   dones;
        int   busys;
        issue(25'h0C00000, 24'h800000);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_ready, out_busy, out_done, out_div_by_zero} !== 4'b1000 ||
            out_quotient !== 24'd0 || out_remainder !== 24'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got rdy/busy/done/dz=%b Q=%h R=%h expected 1000 0 0",
                     {out_ready, out_busy, out_done, out_div_by_zero}, out_quotient, out_remainder);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        watch(30, dones, busys);
        checks++;
        if (dones !== 0 || busys !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got dones=%0d busy=%0d expected 0 0", dones, busys);
        end
        issue(25'h0800000, 24'hFFFFFF);
        sb.push_back(tv_e[4]);
        wait_done(lat);
        got = sb.pop_front();
        checks++;
        if (lat !== 24 || out_quotient !== got.q || out_remainder !== got.r || out_quotient[23] !== 1'b0) begin
            errors++;
            $display("FAIL rst_recover: got lat=%0d Q=%h R=%h expected lat=24 Q=%h R=%h",
                     lat, out_quotient, out_remainder, got.q, got.r);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        last = '0;
        test_reset();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_abort();
        test_rst_mid();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
